// File: rtl/fix_session_pkg.sv
// ----------------------------------------------------------------------------
// fix_session_pkg
//   Constants and types shared by the FIX session-layer heartbeat logic
//   (TX heartbeat scheduler and the RX heartbeat-timeout counter).
//   HB_RANGE      : width of heartbeat interval / idle counters (cycles)
//   TRID_W        : width of the TestReqID(112) field
//   hb_tx_state_t : TX heartbeat scheduler states
// ----------------------------------------------------------------------------
package fix_session_pkg;

    localparam int HB_RANGE = 8;
    localparam int TRID_W   = 32;

    typedef enum logic [1:0] {
        S_OFF    = 2'd0,
        S_COUNT  = 2'd1,
        S_HB_REQ = 2'd2,
        S_TR_REQ = 2'd3
    } hb_tx_state_t;

endpackage

// File: rtl/fix_idle_counter.sv
// ----------------------------------------------------------------------------
// fix_idle_counter
//   Saturating up-counter with synchronous clear and freeze, plus a ">="
//   compare against a programmable limit. A limit of zero disables the
//   compare. Shared by the TX heartbeat scheduler and RX timeout counter.
// Ports
//   clk       in  system clock
//   rst       in  synchronous active-high reset
//   clear_i   in  clear count to 0 (wins over freeze)
//   freeze_i  in  hold the count
//   limit_i   in  compare value; 0 = never reached
//   reached_o out count >= limit_i and limit_i != 0
// ----------------------------------------------------------------------------
module fix_idle_counter #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clear_i,
    input  logic         freeze_i,
    input  logic [W-1:0] limit_i,
    output logic         reached_o
);

    logic [W-1:0] count_q;
    logic [W-1:0] count_d;

    // NOTE: every signal written in always_comb gets a default first, so no
    // path leaves it unassigned and no latch is inferred.
    always_comb begin
        count_d = count_q;
        if (clear_i) begin
            count_d = '0;
        end else if (!freeze_i && (count_q != {W{1'b1}})) begin
            // Saturate at all-ones: a long idle line must never wrap back
            // below the limit and silently skip a heartbeat.
            count_d = count_q + W'(1);
        end
    end

    // NOTE: sequential state is updated with non-blocking assignments so all
    // flops sample the same pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    // Compare is >= so a limit lowered below the current count fires on the
    // next cycle instead of waiting for a wrap.
    assign reached_o = (limit_i != '0) && (count_q >= limit_i);

endmodule

// File: rtl/hb_tx_scheduler.sv
// ----------------------------------------------------------------------------
// hb_tx_scheduler
//   Transmit-side FIX heartbeat scheduler. Requests a Heartbeat(0) when the
//   outbound line has been idle heartbeat_val_i cycles, answers an inbound
//   TestRequest(1) with a Heartbeat echoing its TestReqID, and on an RX
//   heartbeat timeout requests a TestRequest(1); a second timeout with no
//   inbound traffic in between flags the link dead.
// Ports
//   clk, rst          clock, synchronous active-high reset
//   enable_i          session logged on; 0 forces S_OFF and clears everything
//   heartbeat_val_i   idle interval in cycles; 0 disables periodic heartbeats
//   msg_sent_i        strobe: outbound message committed (restarts idle time)
//   test_req_i        strobe: inbound TestRequest, ID on test_req_id_i
//   rx_timeout_i      strobe: RX heartbeat timeout
//   rx_msg_i          strobe: any valid inbound message
//   req_ack_i         TX builder accepted the asserted request
//   hb_req_o          request a Heartbeat
//   hb_has_id_o       Heartbeat carries hb_id_o as TestReqID(112)
//   hb_id_o           TestReqID to echo
//   tr_req_o          request a TestRequest
//   link_dead_o       sticky: peer unresponsive
// ----------------------------------------------------------------------------
module hb_tx_scheduler #(
    parameter int HB_RANGE = fix_session_pkg::HB_RANGE,
    parameter int TRID_W   = fix_session_pkg::TRID_W
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                enable_i,
    input  logic [HB_RANGE-1:0] heartbeat_val_i,
    input  logic                msg_sent_i,
    input  logic                test_req_i,
    input  logic [TRID_W-1:0]   test_req_id_i,
    input  logic                rx_timeout_i,
    input  logic                rx_msg_i,
    output logic                hb_req_o,
    output logic                hb_has_id_o,
    output logic [TRID_W-1:0]   hb_id_o,
    output logic                tr_req_o,
    input  logic                req_ack_i,
    output logic                link_dead_o
);

    import fix_session_pkg::hb_tx_state_t;
    import fix_session_pkg::S_OFF;
    import fix_session_pkg::S_COUNT;
    import fix_session_pkg::S_HB_REQ;
    import fix_session_pkg::S_TR_REQ;

    hb_tx_state_t      state_q, state_d;
    logic              id_pending_q, id_pending_d;
    logic [TRID_W-1:0] id_q, id_d;
    logic              tr_pending_q, tr_pending_d;
    logic              need_tr_q, need_tr_d;
    logic              link_dead_q, link_dead_d;
    logic              hb_req_q, hb_req_d;
    logic              hb_has_id_q, hb_has_id_d;
    logic [TRID_W-1:0] hb_id_q, hb_id_d;
    logic              tr_req_q, tr_req_d;

    logic              cnt_clear;
    logic              cnt_freeze;
    logic              cnt_reached;

    fix_idle_counter #(
        .W (HB_RANGE)
    ) u_idle_cnt (
        .clk       (clk),
        .rst       (rst),
        .clear_i   (cnt_clear),
        .freeze_i  (cnt_freeze),
        .limit_i   (heartbeat_val_i),
        .reached_o (cnt_reached)
    );

    always_comb begin
        state_d      = state_q;
        id_pending_d = id_pending_q;
        id_d         = id_q;
        tr_pending_d = tr_pending_q;
        need_tr_d    = need_tr_q;
        link_dead_d  = link_dead_q;
        hb_req_d     = hb_req_q;
        hb_has_id_d  = hb_has_id_q;
        hb_id_d      = hb_id_q;
        tr_req_d     = tr_req_q;
        cnt_clear    = 1'b0;
        // Idle time only accrues while no request is outstanding.
        cnt_freeze   = (state_q != S_COUNT);

        if (!enable_i) begin
            state_d      = S_OFF;
            id_pending_d = 1'b0;
            id_d         = '0;
            tr_pending_d = 1'b0;
            need_tr_d    = 1'b0;
            link_dead_d  = 1'b0;
            hb_req_d     = 1'b0;
            hb_has_id_d  = 1'b0;
            hb_id_d      = '0;
            tr_req_d     = 1'b0;
            cnt_clear    = 1'b1;
        end else begin
            case (state_q)
                S_OFF: begin
                    state_d   = S_COUNT;
                    cnt_clear = 1'b1;
                end
                S_COUNT: begin
                    cnt_clear = msg_sent_i;
                    // Priority: TestRequest reply > our TestRequest > periodic.
                    // Pending flags are consumed when the request is loaded;
                    // the output registers keep the ID stable until ack, and
                    // a strobe arriving during the hold queues a fresh one.
                    if (id_pending_q) begin
                        state_d      = S_HB_REQ;
                        hb_req_d     = 1'b1;
                        hb_has_id_d  = 1'b1;
                        hb_id_d      = id_q;
                        id_pending_d = 1'b0;
                    end else if (need_tr_q) begin
                        state_d   = S_TR_REQ;
                        tr_req_d  = 1'b1;
                        need_tr_d = 1'b0;
                    end else if (cnt_reached && !msg_sent_i) begin
                        // A message sent this cycle already proves liveness.
                        state_d     = S_HB_REQ;
                        hb_req_d    = 1'b1;
                        hb_has_id_d = 1'b0;
                        hb_id_d     = '0;
                    end
                end
                S_HB_REQ: begin
                    if (req_ack_i) begin
                        state_d     = S_COUNT;
                        hb_req_d    = 1'b0;
                        hb_has_id_d = 1'b0;
                        hb_id_d     = '0;
                        cnt_clear   = 1'b1;
                    end
                end
                S_TR_REQ: begin
                    if (req_ack_i) begin
                        state_d   = S_COUNT;
                        tr_req_d  = 1'b0;
                        cnt_clear = 1'b1;
                    end
                end
                default: begin
                    state_d = S_OFF;
                end
            endcase

            // Session events are tracked in every logged-on state.
            if (state_q != S_OFF) begin
                if (test_req_i) begin
                    id_pending_d = 1'b1;
                    id_d         = test_req_id_i;
                end
                if (rx_msg_i) begin
                    tr_pending_d = 1'b0;
                end
                if (rx_timeout_i) begin
                    if (tr_pending_q) begin
                        link_dead_d = 1'b1;
                    end else if (!link_dead_q) begin
                        tr_pending_d = 1'b1;
                        need_tr_d    = 1'b1;
                    end
                end
                // A dead link gets no further TestRequests.
                if (link_dead_d) begin
                    need_tr_d = 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_OFF;
            id_pending_q <= 1'b0;
            id_q         <= '0;
            tr_pending_q <= 1'b0;
            need_tr_q    <= 1'b0;
            link_dead_q  <= 1'b0;
            hb_req_q     <= 1'b0;
            hb_has_id_q  <= 1'b0;
            hb_id_q      <= '0;
            tr_req_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            id_pending_q <= id_pending_d;
            id_q         <= id_d;
            tr_pending_q <= tr_pending_d;
            need_tr_q    <= need_tr_d;
            link_dead_q  <= link_dead_d;
            hb_req_q     <= hb_req_d;
            hb_has_id_q  <= hb_has_id_d;
            hb_id_q      <= hb_id_d;
            tr_req_q     <= tr_req_d;
        end
    end

    assign hb_req_o    = hb_req_q;
    assign hb_has_id_o = hb_has_id_q;
    assign hb_id_o     = hb_id_q;
    assign tr_req_o    = tr_req_q;
    assign link_dead_o = link_dead_q;

endmodule

// File: tb/tb_hb_tx_scheduler.sv
// ----------------------------------------------------------------------------
// tb_hb_tx_scheduler
//   Self-checking bench for hb_tx_scheduler: a table of hand-derived vectors,
//   directed multi-cycle sequences, and randomized traffic compared each
//   cycle against a behavioural model of the session rules.
// ----------------------------------------------------------------------------
module tb_hb_tx_scheduler;

    localparam int HBW    = 8;
    localparam int IDW    = 32;
    localparam int CNTMAX = (1 << HBW) - 1;

    logic           clk = 1'b0;
    logic           rst;
    logic           enable;
    logic [HBW-1:0] hb_val;
    logic           msg_sent;
    logic           test_req;
    logic [IDW-1:0] test_req_id;
    logic           rx_timeout;
    logic           rx_msg;
    logic           req_ack;
    logic           hb_req;
    logic           hb_has_id;
    logic [IDW-1:0] hb_id;
    logic           tr_req;
    logic           link_dead;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    hb_tx_scheduler #(
        .HB_RANGE (HBW),
        .TRID_W   (IDW)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .enable_i        (enable),
        .heartbeat_val_i (hb_val),
        .msg_sent_i      (msg_sent),
        .test_req_i      (test_req),
        .test_req_id_i   (test_req_id),
        .rx_timeout_i    (rx_timeout),
        .rx_msg_i        (rx_msg),
        .hb_req_o        (hb_req),
        .hb_has_id_o     (hb_has_id),
        .hb_id_o         (hb_id),
        .tr_req_o        (tr_req),
        .req_ack_i       (req_ack),
        .link_dead_o     (link_dead)
    );

    // ---------------- behavioural model ----------------
    // m_out: which request is on the wire (0 none, 1 heartbeat, 2 TestRequest)
    bit             m_on;
    int             m_out;
    int             m_idle;
    bit             m_id_wait;
    logic [IDW-1:0] m_id;
    bit             m_tr_wait;
    bit             m_tr_need;
    bit             m_dead;
    bit             m_has_id;
    logic [IDW-1:0] m_oid;

    task automatic model_update();
        bit id_wait0;
        bit tr_need0;
        bit tr_wait0;
        bit dead0;
        id_wait0 = m_id_wait;
        tr_need0 = m_tr_need;
        tr_wait0 = m_tr_wait;
        dead0    = m_dead;
        if (!enable) begin
            m_on = 0; m_out = 0; m_idle = 0; m_id_wait = 0; m_id = '0;
            m_tr_wait = 0; m_tr_need = 0; m_dead = 0; m_has_id = 0; m_oid = '0;
            return;
        end
        if (!m_on) begin
            m_on   = 1;
            m_idle = 0;
            return;
        end
        if (m_out == 0) begin
            if (id_wait0) begin
                m_out = 1; m_has_id = 1; m_oid = m_id; m_id_wait = 0;
            end else if (tr_need0) begin
                m_out = 2; m_tr_need = 0;
            end else if (int'(hb_val) != 0 && m_idle >= int'(hb_val) && !msg_sent) begin
                m_out = 1; m_has_id = 0; m_oid = '0;
            end
            m_idle = msg_sent ? 0 : ((m_idle < CNTMAX) ? m_idle + 1 : CNTMAX);
        end else if (req_ack) begin
            m_out = 0; m_has_id = 0; m_oid = '0; m_idle = 0;
        end
        if (test_req) begin
            m_id_wait = 1;
            m_id      = test_req_id;
        end
        if (rx_msg) m_tr_wait = 0;
        if (rx_timeout) begin
            if (tr_wait0) m_dead = 1;
            else if (!dead0) begin
                m_tr_wait = 1;
                m_tr_need = 1;
            end
        end
        if (m_dead) m_tr_need = 0;
    endtask

    // ---------------- checking helpers ----------------
    task automatic check(input string name, input logic [35:0] act, input logic [35:0] expv);
        n_vec++;
        if (act !== expv) begin
            n_err++;
            $display("FAIL %s @%0t: got %h, expected %h", name, $time, act, expv);
        end
    endtask

    function automatic logic [35:0] dut_vec();
        return {hb_req, hb_has_id, tr_req, link_dead, hb_id};
    endfunction

    function automatic logic [35:0] model_vec();
        return {(m_out == 1), m_has_id, (m_out == 2), m_dead, m_oid};
    endfunction

    // One clock: DUT and model both consume the current inputs, then compare.
    task automatic step();
        @(posedge clk);
        model_update();
        #1;
        check("model", dut_vec(), model_vec());
    endtask

    task automatic clear_strobes();
        msg_sent = 0; test_req = 0; rx_timeout = 0; rx_msg = 0; req_ack = 0;
    endtask

    // Steps until hb_req rises; n is the number of steps taken (bounded).
    task automatic wait_hb(output int n);
        n = 0;
        do begin
            step();
            n++;
        end while (!hb_req && n < 40);
    endtask

    task automatic restart(input logic [HBW-1:0] v);
        clear_strobes();
        enable = 0;
        step();
        enable = 1;
        hb_val = v;
        step();
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic           en;
        logic           msg;
        logic           treq;
        logic [IDW-1:0] tid;
        logic           to;
        logic           ack;
        logic [35:0]    expv;
    } vec_t;

    vec_t tbl[17];

    function automatic vec_t mk(input logic en, input logic msg, input logic treq,
                                input logic [IDW-1:0] tid, input logic to, input logic ack,
                                input logic [35:0] expv);
        vec_t v;
        v.en = en; v.msg = msg; v.treq = treq; v.tid = tid; v.to = to; v.ack = ack;
        v.expv = expv;
        return v;
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int seen;
        logic [IDW-1:0] beef;

        beef = 32'hDEAD_BEEF;
        // Interval 3; exp = {hb_req, hb_has_id, tr_req, link_dead, hb_id}
        tbl[0]  = mk(1, 0, 0, '0,   0, 0, {4'b0000, 32'h0}); // enter S_COUNT
        tbl[1]  = mk(1, 0, 0, '0,   0, 0, {4'b0000, 32'h0});
        tbl[2]  = mk(1, 0, 0, '0,   0, 0, {4'b0000, 32'h0});
        tbl[3]  = mk(1, 0, 0, '0,   0, 0, {4'b0000, 32'h0});
        tbl[4]  = mk(1, 0, 0, '0,   0, 0, {4'b1000, 32'h0}); // periodic heartbeat
        tbl[5]  = mk(1, 0, 0, '0,   0, 1, {4'b0000, 32'h0}); // ack
        tbl[6]  = mk(1, 0, 1, beef, 1, 0, {4'b0000, 32'h0}); // TestRequest + timeout together
        tbl[7]  = mk(1, 0, 0, '0,   0, 0, {4'b1100, beef});  // ID reply first
        tbl[8]  = mk(1, 0, 0, '0,   0, 0, {4'b1100, beef});  // held without ack
        tbl[9]  = mk(1, 0, 0, '0,   0, 1, {4'b0000, 32'h0});
        tbl[10] = mk(1, 0, 0, '0,   0, 0, {4'b0010, 32'h0}); // then TestRequest
        tbl[11] = mk(1, 0, 0, '0,   0, 1, {4'b0000, 32'h0});
        tbl[12] = mk(1, 0, 0, '0,   1, 0, {4'b0001, 32'h0}); // second timeout: dead
        tbl[13] = mk(1, 0, 0, '0,   0, 0, {4'b0001, 32'h0});
        tbl[14] = mk(1, 0, 0, '0,   0, 0, {4'b0001, 32'h0});
        tbl[15] = mk(1, 0, 0, '0,   0, 0, {4'b1001, 32'h0}); // heartbeats continue
        tbl[16] = mk(0, 0, 0, '0,   0, 0, {4'b0000, 32'h0}); // disable clears all

        rst = 1; enable = 0; hb_val = '0; test_req_id = '0;
        clear_strobes();
        m_on = 0; m_out = 0; m_idle = 0; m_id_wait = 0; m_id = '0;
        m_tr_wait = 0; m_tr_need = 0; m_dead = 0; m_has_id = 0; m_oid = '0;
        repeat (3) @(posedge clk);
        #1;
        check("reset", dut_vec(), 36'h0);
        rst = 0;
        step();

        // Table
        hb_val = 8'd3;
        for (int i = 0; i < 17; i++) begin
            enable = tbl[i].en; msg_sent = tbl[i].msg; test_req = tbl[i].treq;
            test_req_id = tbl[i].tid; rx_timeout = tbl[i].to; req_ack = tbl[i].ack;
            rx_msg = 0;
            step();
            check($sformatf("tbl%0d", i), dut_vec(), tbl[i].expv);
        end
        clear_strobes();

        // Periodic heartbeat: 11 cycles after entry, ack after 2 cycles held
        restart(8'd10);
        for (int k = 0; k < 3; k++) begin
            wait_hb(n);
            check($sformatf("period_rise%0d", k), 36'(n), 36'd11);
            step();
            req_ack = 1;
            step();
            req_ack = 0;
        end

        // Traffic every 8 cycles keeps heartbeats away
        restart(8'd10);
        seen = 0;
        for (int i = 0; i < 80; i++) begin
            msg_sent = (i % 8 == 7);
            step();
            if (hb_req) seen++;
        end
        msg_sent = 0;
        check("traffic_no_hb", 36'(seen), 36'd0);

        // TestRequest once, then dead; further timeouts issue nothing
        restart(8'd0);
        rx_timeout = 1;
        step();
        rx_timeout = 0;
        n = 0;
        do begin step(); n++; end while (!tr_req && n < 10);
        check("tr_issued", 36'(tr_req), 36'd1);
        req_ack = 1;
        step();
        req_ack = 0;
        rx_timeout = 1;
        step();
        rx_timeout = 0;
        check("link_dead", 36'(link_dead), 36'd1);
        seen = 0;
        for (int i = 0; i < 20; i++) begin
            rx_timeout = (i % 5 == 0);
            rx_msg = (i == 7);
            step();
            if (tr_req) seen++;
        end
        clear_strobes();
        check("no_tr_after_dead", 36'(seen), 36'd0);
        check("dead_sticky", 36'(link_dead), 36'd1);

        // Disable with heartbeat held, then re-enable restarts idle time
        restart(8'd10);
        repeat (14) step();
        check("hb_held", 36'(hb_req), 36'd1);
        enable = 0;
        step();
        check("off_clears", dut_vec(), 36'h0);
        enable = 1;
        step();
        wait_hb(n);
        check("reenable_rise", 36'(n), 36'd11);

        // Saturation: counter parks at all-ones, so limit 255 fires at once
        restart(8'd0);
        seen = 0;
        for (int i = 0; i < 300; i++) begin
            step();
            if (hb_req) seen++;
        end
        check("disabled_no_hb", 36'(seen), 36'd0);
        hb_val = 8'd255;
        step();
        check("saturated_hb", 36'(hb_req), 36'd1);

        // Lowering the interval below the running count fires next cycle
        restart(8'd200);
        repeat (50) step();
        hb_val = 8'd20;
        step();
        check("lowered_hb", 36'(hb_req), 36'd1);

        // Randomized traffic against the model
        for (int i = 0; i < 3000; i++) begin
            enable = ($urandom_range(199) != 0);
            if ($urandom_range(49) == 0) hb_val = HBW'($urandom_range(12));
            msg_sent    = ($urandom_range(11) == 0);
            test_req    = ($urandom_range(19) == 0);
            test_req_id = $urandom();
            rx_timeout  = ($urandom_range(29) == 0);
            rx_msg      = ($urandom_range(9) == 0);
            req_ack     = ($urandom_range(2) == 0);
            step();
        end
        clear_strobes();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
